// File: rtl/fp16_mac_pkg.sv
// Shared constants and types for the FP16 multiply datapath.
package fp16_mac_pkg;

  localparam int unsigned FP16_BIAS = 15;
  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_MAXN = 16'h7BFF;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fp16_flags_t;

  // Operand class carried alongside the normalized mantissa.
  typedef enum logic [1:0] {
    ClsNorm,
    ClsZero,
    ClsInf,
    ClsNan
  } fp16_cls_t;

endpackage

// File: rtl/fp16_lzc22.sv
// 22-bit leading-zero counter, purely combinational. All-zero input yields 22.
module fp16_lzc22 (
  input  logic [21:0] data_i,
  output logic [4:0]  count_o
);

  // Count zeros from the MSB down until the first set bit.
  always_comb begin
    logic found;
    found   = 1'b0;
    count_o = 5'd0;
    for (int i = 21; i >= 0; i--) begin
      if (!found) begin
        if (data_i[i]) found = 1'b1;
        else           count_o = count_o + 5'd1;
      end
    end
  end

endmodule

// File: rtl/fp16_product_normalizer.sv
// Two-stage normalize / round / pack stage for an FP16 product.
// S1 normalizes the raw 22-bit mantissa product, S2 rounds, packs and registers.
// Build option: define FP16_NORM_RNE_EN for round-to-nearest-even; otherwise
// results are truncated and overflow saturates to the largest finite value.
// EXP_W must be at least 5.
module fp16_product_normalizer
  import fp16_mac_pkg::*;
#(
  parameter int unsigned EXP_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp_sum,
  input  logic [21:0]      in_mant,
  input  logic             in_is_zero,
  input  logic             in_is_inf,
  input  logic             in_is_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_fp16,
  output logic [2:0]       out_flags
);

  // One bit wider than the input so normalize/round adjustments never wrap.
  localparam logic signed [EXP_W:0] ExpOne  = (EXP_W + 1)'(1);
  localparam logic signed [EXP_W:0] ExpZero = (EXP_W + 1)'(0);
  localparam logic signed [EXP_W:0] ExpMax  = (EXP_W + 1)'(2 * FP16_BIAS + 1);

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_sign_q, s1_sign_d;
  logic signed [EXP_W:0]   s1_exp_q, s1_exp_d;
  logic [9:0]              s1_frac_q, s1_frac_d;
  logic                    s1_guard_q, s1_guard_d;
  logic                    s1_sticky_q, s1_sticky_d;
  fp16_cls_t               s1_cls_q, s1_cls_d;
  logic                    out_valid_q, out_valid_d;
  logic [15:0]             out_fp16_q, out_fp16_d;
  fp16_flags_t             out_flags_q, out_flags_d;

  logic                    s1_adv, in_fire, s2_load;
  logic [4:0]              lz, shamt;
  logic signed [EXP_W:0]   exp_in, shamt_ext;

  fp16_lzc22 u_lzc (
    .data_i  (in_mant),
    .count_o (lz)
  );

  assign s1_adv   = !out_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || s1_adv);
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_adv && s1_valid_q;

  assign exp_in    = {in_exp_sum[EXP_W-1], in_exp_sum};
  // Zeros above the leading one at bit 20; only meaningful when bits 21:20 are 00.
  assign shamt     = lz - 5'd1;
  assign shamt_ext = $signed({{(EXP_W - 4){1'b0}}, shamt});

  // S1: normalize so the hidden one sits at bit 20, then split frac/guard/sticky.
  always_comb begin
    logic [19:0] norm;
    logic        shifted_out;
    logic signed [EXP_W:0] exp_norm;
    norm        = in_mant[19:0];
    shifted_out = 1'b0;
    exp_norm    = exp_in;
    if (in_mant[21]) begin
      norm        = in_mant[20:1];
      shifted_out = in_mant[0];
      exp_norm    = exp_in + ExpOne;
    end else if (!in_mant[20] && (in_mant != '0)) begin
      // The leading one lands on bit 20 and drops out of this 20-bit window.
      norm     = in_mant[19:0] << shamt;
      exp_norm = exp_in - shamt_ext;
    end

    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_frac_d   = s1_frac_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_cls_d    = s1_cls_q;
    if (in_fire) begin
      s1_sign_d   = in_sign;
      s1_exp_d    = exp_norm;
      s1_frac_d   = norm[19:10];
      s1_guard_d  = norm[9];
      s1_sticky_d = (|norm[8:0]) | shifted_out;
      if (in_is_nan)                         s1_cls_d = ClsNan;
      else if (in_is_inf)                    s1_cls_d = ClsInf;
      else if (in_is_zero || in_mant == '0)  s1_cls_d = ClsZero;
      else                                   s1_cls_d = ClsNorm;
    end
  end

  // S2: round, range-check and pack into the output register.
  always_comb begin
    logic                  round_up;
    logic [10:0]           frac_sum;
    logic signed [EXP_W:0] exp_fin;
    logic                  inexact;
    logic [15:0]           res;
    fp16_flags_t           flags;
`ifdef FP16_NORM_RNE_EN
    round_up = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
`else
    round_up = 1'b0;
`endif
    frac_sum = {1'b0, s1_frac_q} + {10'b0, round_up};
    // A carry-out leaves the fraction bits at zero already.
    exp_fin  = frac_sum[10] ? (s1_exp_q + ExpOne) : s1_exp_q;
    inexact  = s1_guard_q | s1_sticky_q;
    res      = '0;
    flags    = '0;
    unique case (s1_cls_q)
      ClsNan:  res = FP16_QNAN;
      ClsInf:  res = {s1_sign_q, FP16_INF[14:0]};
      ClsZero: res = {s1_sign_q, 15'h0};
      ClsNorm: begin
        if (exp_fin >= ExpMax) begin
`ifdef FP16_NORM_RNE_EN
          res = {s1_sign_q, FP16_INF[14:0]};
`else
          res = {s1_sign_q, FP16_MAXN[14:0]};
`endif
          flags = '{overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
        end else if (exp_fin <= ExpZero) begin
          res   = {s1_sign_q, 15'h0};
          flags = '{overflow: 1'b0, underflow: 1'b1, inexact: inexact};
        end else begin
          res   = {s1_sign_q, exp_fin[4:0], frac_sum[9:0]};
          flags = '{overflow: 1'b0, underflow: 1'b0, inexact: inexact};
        end
      end
    endcase

    out_valid_d = s1_adv ? s1_valid_q : out_valid_q;
    out_fp16_d  = s2_load ? res : out_fp16_q;
    out_flags_d = s2_load ? flags : out_flags_q;
  end

  // Pipeline state; reset drops every in-flight beat immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_cls_q    <= ClsNorm;
      out_valid_q <= 1'b0;
      out_fp16_q  <= '0;
      out_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_frac_q   <= s1_frac_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s1_cls_q    <= s1_cls_d;
      out_valid_q <= out_valid_d;
      out_fp16_q  <= out_fp16_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_fp16  = out_fp16_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp16_product_normalizer.sv
// Directed, table-driven bench for fp16_product_normalizer.
module tb_fp16_product_normalizer;

`ifdef FP16_NORM_RNE_EN
  localparam logic [15:0] ExpRnd   = 16'h3C02;
  localparam logic [15:0] ExpOvf   = 16'h7C00;
  localparam logic [15:0] ExpOvfN  = 16'hFC00;
  localparam logic [15:0] ExpCarry = 16'h4000;
`else
  localparam logic [15:0] ExpRnd   = 16'h3C01;
  localparam logic [15:0] ExpOvf   = 16'h7BFF;
  localparam logic [15:0] ExpOvfN  = 16'hFBFF;
  localparam logic [15:0] ExpCarry = 16'h3FFF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_is_zero, in_is_inf, in_is_nan;
  logic [6:0]  in_exp_sum;
  logic [21:0] in_mant;
  logic        out_valid, out_ready;
  logic [15:0] out_fp16;
  logic [2:0]  out_flags;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        sign;
    logic [6:0]  exp_sum;
    logic [21:0] mant;
    logic        zero;
    logic        inf;
    logic        nan;
    logic [15:0] fp16;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs [16];

  fp16_product_normalizer #(.EXP_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp_sum (in_exp_sum),
    .in_mant    (in_mant),
    .in_is_zero (in_is_zero),
    .in_is_inf  (in_is_inf),
    .in_is_nan  (in_is_nan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fp16   (out_fp16),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    in_sign    = v.sign;
    in_exp_sum = v.exp_sum;
    in_mant    = v.mant;
    in_is_zero = v.zero;
    in_is_inf  = v.inf;
    in_is_nan  = v.nan;
  endtask

  // One beat in, result required exactly two edges after acceptance.
  task automatic run_vec(input int i);
    @(negedge clk);
    out_ready = 1'b1;
    drive(vecs[i]);
    in_valid = 1'b1;
    #1;
    check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check($sformatf("v%0d valid@1", i), 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d valid@2", i), 32'(out_valid), 32'd1);
    check($sformatf("v%0d fp16", i), 32'(out_fp16), 32'(vecs[i].fp16));
    check($sformatf("v%0d flags", i), 32'(out_flags), 32'(vecs[i].flags));
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int          sent;
    int          recv;
    logic        fire_in;
    logic [15:0] held;
    logic [2:0]  held_fl;

    //         sign  exp      mant          z     i     n     fp16      flags
    vecs[0]  = '{1'b0, 7'd15,  22'h240000, 1'b0, 1'b0, 1'b0, 16'h4080, 3'b000};
    vecs[1]  = '{1'b0, 7'd15,  22'h100600, 1'b0, 1'b0, 1'b0, ExpRnd,   3'b001};
    vecs[2]  = '{1'b0, 7'd15,  22'h100200, 1'b0, 1'b0, 1'b0, 16'h3C00, 3'b001};
    vecs[3]  = '{1'b0, 7'd30,  22'h240000, 1'b0, 1'b0, 1'b0, ExpOvf,   3'b101};
    vecs[4]  = '{1'b1, 7'h7F,  22'h240000, 1'b0, 1'b0, 1'b0, 16'h8000, 3'b010};
    vecs[5]  = '{1'b0, 7'd15,  22'h100000, 1'b1, 1'b1, 1'b1, 16'h7E00, 3'b000};
    vecs[6]  = '{1'b1, 7'd15,  22'h100000, 1'b1, 1'b1, 1'b0, 16'hFC00, 3'b000};
    vecs[7]  = '{1'b1, 7'd15,  22'h100000, 1'b1, 1'b0, 1'b0, 16'h8000, 3'b000};
    vecs[8]  = '{1'b0, 7'd15,  22'h000000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000};
    vecs[9]  = '{1'b0, 7'd15,  22'h080000, 1'b0, 1'b0, 1'b0, 16'h3800, 3'b000};
    vecs[10] = '{1'b0, 7'd15,  22'h1FFE00, 1'b0, 1'b0, 1'b0, ExpCarry, 3'b001};
    vecs[11] = '{1'b0, 7'd15,  22'h300001, 1'b0, 1'b0, 1'b0, 16'h4200, 3'b001};
    vecs[12] = '{1'b0, 7'd40,  22'h000400, 1'b0, 1'b0, 1'b0, 16'h7800, 3'b000};
    vecs[13] = '{1'b0, 7'd15,  22'h000001, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b010};
    vecs[14] = '{1'b1, 7'd63,  22'h100000, 1'b0, 1'b0, 1'b0, ExpOvfN,  3'b101};
    vecs[15] = '{1'b0, 7'd1,   22'h100000, 1'b0, 1'b0, 1'b0, 16'h0400, 3'b000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(vecs[0]);

    // Reset state and release.
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst fp16", 32'(out_fp16), 32'd0);
    check("rst flags", 32'(out_flags), 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) run_vec(i);

    // Backpressure: four beats, output stalled for three cycles.
    drain();
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (sent < 4) begin
        drive(vecs[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        check("stall in_ready", 32'(in_ready), 32'd0);
        check("stall accepted", 32'(sent), 32'd2);
        check("stall valid", 32'(out_valid), 32'd1);
        held    = out_fp16;
        held_fl = out_flags;
      end
      if (cyc == 3 || cyc == 4) begin
        check($sformatf("hold fp16 c%0d", cyc), 32'(out_fp16), 32'(held));
        check($sformatf("hold flags c%0d", cyc), 32'(out_flags), 32'(held_fl));
        check($sformatf("hold valid c%0d", cyc), 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream fp16 #%0d", recv), 32'(out_fp16), 32'(vecs[recv].fp16));
        check($sformatf("stream flags #%0d", recv), 32'(out_flags), 32'(vecs[recv].flags));
        recv++;
      end
      fire_in = in_valid && in_ready;
      @(posedge clk);
      if (fire_in) sent++;
    end
    check("stream count", 32'(recv), 32'd4);

    // Asynchronous reset with a result pending.
    drain();
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre-rst valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd0);
    check("async rst fp16", 32'(out_fp16), 32'd0);
    check("async rst flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rerelease in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("no stale beat", 32'(out_valid), 32'd0);
    run_vec(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
